// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control logic: FSM encodings and flush length default.
package mips_ctrl_pkg;

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StStepIdle = 2'd1;
    localparam logic [1:0] StStepAdv  = 2'd2;
    localparam logic [1:0] StHalted   = 2'd3;

    localparam int unsigned FlushCyclesDef = 2;
    localparam int unsigned FlushCntW      = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/EX/WB status into the hazard controller and its pipeline control outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_nop;
    logic             ex_memRead;
    logic [4:0]       ex_rt;
    logic             jump_taken;
    logic             wb_halt;
    logic             step_mode;
    logic             step_req;
    logic             stall;
    logic             flush;
    logic             ex_bubble;
    logic             pc_write;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_nop, ex_memRead, ex_rt,
               jump_taken, wb_halt, step_mode, step_req,
        input  stall, flush, ex_bubble, pc_write, halted, cycle_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_nop, ex_memRead, ex_rt,
               jump_taken, wb_halt, step_mode, step_req,
        output stall, flush, ex_bubble, pc_write, halted, cycle_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the decode slot.
module hazard_detect (
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       id_nop_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match   = (ex_rt_i == id_rs_i);
        rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
        // $zero never carries a real dependency.
        load_use_o = ex_mem_read_i && !id_nop_i && (ex_rt_i != 5'd0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer around decode: load-use stalls, jump flushes, single-step and halt freeze.
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FlushCyclesDef,
    parameter int unsigned CNT_W        = 32
) (
    input logic                  clock,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;

    logic load_use;
    logic frozen;
    logic jump_eff;
    logic flush_act;

    hazard_detect u_hazard_detect (
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .id_nop_i      (bus.id_nop),
        .ex_mem_read_i (bus.ex_memRead),
        .ex_rt_i       (bus.ex_rt),
        .load_use_o    (load_use)
    );

    always_comb begin
        frozen    = (state_q == StStepIdle) || (state_q == StHalted);
        // A retiring halt pre-empts a jump resolved in the same cycle.
        jump_eff  = !frozen && bus.jump_taken && !bus.wb_halt;
        flush_act = !frozen && (jump_eff || (flush_cnt_q != '0));

        flush_cnt_d = flush_cnt_q;
        if (jump_eff) begin
            flush_cnt_d = FlushLoad;
        end else if (!frozen && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end

        cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, !frozen};

        state_d = state_q;
        case (state_q)
            StRun: begin
                if (bus.wb_halt)        state_d = StHalted;
                else if (bus.step_mode) state_d = StStepIdle;
            end
            StStepIdle: begin
                if (bus.wb_halt)         state_d = StHalted;
                else if (bus.step_req)   state_d = StStepAdv;
                else if (!bus.step_mode) state_d = StRun;
            end
            StStepAdv: begin
                state_d = bus.wb_halt ? StHalted : StStepIdle;
            end
            default: state_d = StHalted;
        endcase
    end

    // Control outputs are forced low while reset is held.
    always_comb begin
        bus.flush       = reset && flush_act;
        bus.stall       = reset && (frozen || (!flush_act && load_use));
        bus.ex_bubble   = reset && !frozen && !flush_act && load_use;
        bus.pc_write    = reset && !frozen && (flush_act || !load_use);
        bus.halted      = (state_q == StHalted);
        bus.cycle_count = cycle_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            flush_cnt_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

endmodule
